// File: rtl/uart_rx_fifo_regfile.sv
// Byte storage for the receive FIFO: synchronous write, asynchronous read.
// Kept separate so the ASIC flow can swap it for a latch array or SRAM macro.
module fifo_regfile #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // which entries are meaningful, and an unreset array maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: never back-pressures, drops bytes
// when full with a sticky overflow flag, first-word-fall-through output.
module uart_rx_fifo #(
  parameter int  DEPTH    = 16,
  parameter int  WIDTH    = 8,
  parameter int  AF_LEVEL = 12,
  localparam int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush,
  input  logic                clear_overflow,
  output logic [CNT_BITS-1:0] count,
  output logic                almost_full,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_in_ready;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // The extra MSB is a wrap bit: equal low bits with differing wrap bits is full.
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_pop   = !w_empty && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
  assign w_push  = in_valid && r_in_ready && !flush && (!w_full || w_pop);
  assign w_drop  = in_valid && r_in_ready && !flush && w_full && !w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_ready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  fifo_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (out_data)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = !w_empty;
  assign count       = r_wr_ptr - r_rd_ptr;
  assign almost_full = (int'(count) >= AF_LEVEL);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AF    = 12;
  localparam int CB    = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic             clear_overflow = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [CB-1:0]    count;
  logic             almost_full;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovf   = 1'b0;
  bit         m_ready = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .count          (count),
    .almost_full    (almost_full),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  // Advance one clock: update the model from the current inputs, then
  // return 1 time unit after the rising edge so outputs are settled.
  task automatic tick();
    bit pop;
    bit full;
    bit drop;
    pop  = (q.size() != 0) && out_ready;
    full = (q.size() == DEPTH);
    drop = 1'b0;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (in_valid && m_ready) begin
        if (!full || pop) q.push_back(in_data);
        else drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 8'hAB;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got v=%b c=%0d o=%b af=%b exp 0/0/0/0", out_valid, count, overflow, almost_full);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_no_write got c=%0d v=%b exp 0/0", count, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic_order();
    logic [7:0] vals [3];
    vals = '{8'h55, 8'hA3, 8'h0F};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      tick();
      checks++;
      if (count !== CB'(i + 1)) begin errors++; $display("FAIL order_count got %0d exp %0d", count, i + 1); end
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55) begin
          errors++; $display("FAIL order_fwft got v=%b d=%h exp 1/55", out_valid, out_data);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        errors++; $display("FAIL order_pop got v=%b d=%h exp 1/%h", out_valid, out_data, vals[i]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      checks++;
      if (count !== CB'(q.size()) || almost_full !== (q.size() >= AF)) begin
        errors++;
        $display("FAIL fill_count got c=%0d af=%b exp c=%0d af=%b", count, almost_full, q.size(), q.size() >= AF);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (count !== CB'(DEPTH) || overflow !== 1'b1) begin
      errors++; $display("FAIL fill_overflow got c=%0d o=%b exp 16/1", count, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_data !== 8'(i)) begin errors++; $display("FAIL fill_drain got %h exp %h", out_data, 8'(i)); end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", out_valid); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fill_clear got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] head;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    checks++;
    if (count !== CB'(DEPTH)) begin errors++; $display("FAIL fpp_fill got %0d exp 16", count); end
    out_ready = 1'b1;
    in_data   = 8'hEE;
    head      = q[0];
    checks++;
    if (out_data !== head) begin errors++; $display("FAIL fpp_head got %h exp %h", out_data, head); end
    tick();
    checks++;
    if (count !== CB'(DEPTH) || overflow !== 1'b0 || q[DEPTH-1] !== 8'hEE) begin
      errors++; $display("FAIL fpp_ee got c=%0d o=%b exp 16/0", count, overflow);
    end
    for (int i = 0; i < 40; i++) begin
      in_data = 8'($urandom);
      checks++;
      if (out_data !== q[0]) begin errors++; $display("FAIL fpp_wrap_data got %h exp %h", out_data, q[0]); end
      tick();
      checks++;
      if (count !== CB'(DEPTH) || overflow !== 1'b0) begin
        errors++; $display("FAIL fpp_wrap_state got c=%0d o=%b exp 16/0", count, overflow);
      end
    end
    in_valid = 1'b0;
    while (q.size() != 0) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== q[0]) begin
        errors++; $display("FAIL fpp_drain got v=%b d=%h exp 1/%h", out_valid, out_data, q[0]);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_clear();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH - 5) tick();
    out_ready = 1'b0;
    checks++;
    if (count !== CB'(5) || overflow !== 1'b1) begin
      errors++; $display("FAIL fc_setup got c=%0d o=%b exp 5/1", count, overflow);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL fc_flush got c=%0d v=%b o=%b exp 0/0/1", count, out_valid, overflow);
    end
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    clear_overflow = 1'b1;
    in_data        = 8'h99;
    tick();
    checks++;
    if (overflow !== 1'b1 || count !== CB'(DEPTH)) begin
      errors++; $display("FAIL fc_set_wins got o=%b c=%0d exp 1/16", overflow, count);
    end
    in_valid = 1'b0;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fc_clear got %b exp 0", overflow); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== CB'(7)) begin errors++; $display("FAIL ar_setup got %0d exp 7", count); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ar_immediate got c=%0d v=%b r=%b exp 0/0/0", count, out_valid, in_ready);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== CB'(1) || out_valid !== 1'b1 || out_data !== 8'h3C) begin
      errors++; $display("FAIL ar_resume got c=%0d v=%b d=%h exp 1/1/3c", count, out_valid, out_data);
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) == 0);
      in_data        = 8'($urandom);
      flush          = ($urandom_range(0, 63) == 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (count !== CB'(q.size()) || out_valid !== (q.size() != 0) ||
          almost_full !== (q.size() >= AF) || overflow !== m_ovf || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd_state got c=%0d v=%b af=%b o=%b exp c=%0d o=%b", count, out_valid, almost_full, overflow, q.size(), m_ovf);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_data !== q[0]) begin errors++; $display("FAIL rnd_data got %h exp %h", out_data, q[0]); end
      end
    end
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    flush          = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_fill_overflow();
    test_full_push_pop();
    test_flush_clear();
    test_async_reset();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
